// File: rtl/cv32e40px_pkg.sv
// Shared types and constants for the fetch aligner.
//   align_state_e : aligner FSM states
//   OPCODE_C_MASK : low opcode bits; both set means a 32-bit instruction
package cv32e40px_pkg;

  typedef enum logic [1:0] {
    ALIGNED    = 2'd0,
    MISALIGNED = 2'd1,
    BRANCH_MIS = 2'd2
  } align_state_e;

  localparam logic [1:0] OPCODE_C_MASK = 2'b11;

  // True when a halfword starts a 16-bit compressed instruction.
  function automatic logic is_compressed(input logic [15:0] hw);
    return (hw[1:0] & OPCODE_C_MASK) != OPCODE_C_MASK;
  endfunction

endpackage

// File: rtl/cv32e40px_fetch_aligner.sv
// Fetch aligner: turns 32-bit word-aligned fetch words from the prefetch FIFO
// into one RISC-V instruction (32-bit or 16-bit compressed) per handshake,
// together with its PC. A single 16-bit residual halfword is kept so the FIFO
// head can be popped as soon as its lower half has been used.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   branch_i/branch_addr_i redirect and target (bit 0 ignored)
//   fetch_valid_i          FIFO head valid
//   fetch_rdata_i          FIFO head word
//   fetch_ready_o          pop FIFO head
//   instr_valid_o          instr_o/pc_o valid
//   instr_ready_i          IF/ID accepts
//   instr_o                aligned instruction, compressed -> {16'h0, hw}
//   instr_compressed_o     instr_o is a 16-bit instruction
//   pc_o                   PC of instr_o
//
// Handshakes: a FIFO pop happens when fetch_valid_i & fetch_ready_o; an
// instruction is transferred when instr_valid_o & instr_ready_i. Neither valid
// depends on its own ready; fetch_ready_o follows instr_ready_i whenever the
// current instruction needs the FIFO head word.
module cv32e40px_fetch_aligner
  import cv32e40px_pkg::*;
#(
  parameter bit          COMPRESSED_EN = 1'b1,
  parameter logic [31:0] RESET_PC      = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        instr_compressed_o,
  output logic [31:0] pc_o
);

  align_state_e r_state;
  logic [31:0]  r_pc;
  logic [15:0]  r_residual;

  align_state_e w_next_state;
  logic [31:0]  w_next_pc;
  logic [15:0]  w_next_residual;
  logic         w_valid;
  logic         w_ready;
  logic         w_handshake;
  logic [31:0]  w_instr;
  logic [31:0]  w_target;
  logic         w_target_mis;
  logic         w_unused;

  // Bit 0 of the target is meaningless for halfword-aligned code.
  assign w_unused     = branch_addr_i[0];
  assign w_target_mis = branch_addr_i[1] & COMPRESSED_EN;
  assign w_target     = {branch_addr_i[31:2], w_target_mis, 1'b0};

  always_comb begin
    w_valid         = 1'b0;
    w_ready         = 1'b0;
    w_instr         = fetch_rdata_i;
    w_next_state    = r_state;
    w_next_pc       = r_pc;
    w_next_residual = r_residual;
    w_handshake     = 1'b0;

    case (r_state)
      ALIGNED: begin
        w_valid     = fetch_valid_i;
        w_ready     = instr_ready_i;
        w_handshake = fetch_valid_i & instr_ready_i;
        if (COMPRESSED_EN && is_compressed(fetch_rdata_i[15:0])) begin
          w_instr = {16'h0, fetch_rdata_i[15:0]};
          if (w_handshake) begin
            w_next_residual = fetch_rdata_i[31:16];
            w_next_pc       = r_pc + 32'd2;
            w_next_state    = MISALIGNED;
          end
        end else if (w_handshake) begin
          w_next_pc = r_pc + 32'd4;
        end
      end

      MISALIGNED: begin
        if (is_compressed(r_residual)) begin
          // Residual is a whole instruction: no FIFO word needed.
          w_valid     = 1'b1;
          w_instr     = {16'h0, r_residual};
          w_handshake = instr_ready_i;
          if (w_handshake) begin
            w_next_pc    = r_pc + 32'd2;
            w_next_state = ALIGNED;
          end
        end else begin
          // Straddling instruction: upper half comes from the FIFO head.
          w_valid     = fetch_valid_i;
          w_ready     = instr_ready_i;
          w_instr     = {fetch_rdata_i[15:0], r_residual};
          w_handshake = fetch_valid_i & instr_ready_i;
          if (w_handshake) begin
            w_next_residual = fetch_rdata_i[31:16];
            w_next_pc       = r_pc + 32'd4;
          end
        end
      end

      BRANCH_MIS: begin
        // Drop the lower half of the target word; keep the upper half.
        w_ready = 1'b1;
        if (fetch_valid_i) begin
          w_next_residual = fetch_rdata_i[31:16];
          w_next_state    = MISALIGNED;
        end
      end

      default: begin
        w_next_state = ALIGNED;
      end
    endcase

    if (branch_i) begin
      w_valid         = 1'b0;
      w_ready         = 1'b0;
      w_next_pc       = w_target;
      w_next_residual = 16'h0;
      w_next_state    = w_target_mis ? BRANCH_MIS : ALIGNED;
    end

    if (!rst_ni) begin
      w_valid = 1'b0;
      w_ready = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ALIGNED;
      r_pc       <= RESET_PC;
      r_residual <= 16'h0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_residual <= w_next_residual;
    end
  end

  assign instr_valid_o      = w_valid;
  assign fetch_ready_o      = w_ready;
  assign instr_o            = w_instr;
  assign instr_compressed_o = COMPRESSED_EN & is_compressed(w_instr[15:0]);
  assign pc_o               = r_pc;

endmodule

// File: tb/tb_cv32e40px_fetch_aligner.sv
module tb_cv32e40px_fetch_aligner;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic        instr_compressed_o;
  logic [31:0] pc_o;

  always #5 clk_i = ~clk_i;

  cv32e40px_fetch_aligner dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .branch_i          (branch_i),
    .branch_addr_i     (branch_addr_i),
    .fetch_valid_i     (fetch_valid_i),
    .fetch_rdata_i     (fetch_rdata_i),
    .fetch_ready_o     (fetch_ready_o),
    .instr_valid_o     (instr_valid_o),
    .instr_ready_i     (instr_ready_i),
    .instr_o           (instr_o),
    .instr_compressed_o(instr_compressed_o),
    .pc_o              (pc_o)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Bench-side prefetch FIFO contents (head at index 0).
  logic [31:0] fifo_q[$];

  // Reference model: a stream of not-yet-issued halfwords plus the PC.
  logic [15:0] pend_q[$];
  logic [31:0] m_pc;
  logic        m_skip;

  // Model predictions for the current cycle.
  logic        e_valid, e_ready, e_pop, e_hs;
  logic [31:0] e_instr;
  logic [2:0]  e_adv;

  // Sampled DUT outputs of the last cycle.
  logic        s_valid, s_ready, s_comp;
  logic [31:0] s_instr, s_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_c(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

  task automatic model_reset();
    pend_q.delete();
    m_pc   = 32'h0;
    m_skip = 1'b0;
  endtask

  // Predict outputs from the halfword stream: an instruction needs the FIFO
  // head only when the pending halfwords cannot complete it by themselves.
  task automatic model_eval(input logic fv, input logic [31:0] w, input logic rdy,
                            input logic br, input logic rst);
    e_valid = 1'b0; e_ready = 1'b0; e_pop = 1'b0; e_hs = 1'b0;
    e_instr = 32'h0; e_adv = 3'd0;
    if (rst && !br) begin
      if (m_skip) begin
        e_ready = 1'b1;
        e_pop   = fv;
      end else if (pend_q.size() > 0 && is_c(pend_q[0])) begin
        e_valid = 1'b1;
        e_instr = {16'h0, pend_q[0]};
        e_adv   = 3'd2;
      end else begin
        e_valid = fv;
        e_ready = rdy;
        e_pop   = fv & rdy;
        if (pend_q.size() > 0) begin
          e_instr = {w[15:0], pend_q[0]};
          e_adv   = 3'd4;
        end else if (is_c(w[15:0])) begin
          e_instr = {16'h0, w[15:0]};
          e_adv   = 3'd2;
        end else begin
          e_instr = w;
          e_adv   = 3'd4;
        end
      end
      e_hs = e_valid & rdy;
    end
  endtask

  task automatic model_commit(input logic fv, input logic [31:0] w, input logic br,
                              input logic [31:0] baddr, input logic rst);
    if (!rst) begin
      model_reset();
    end else if (br) begin
      pend_q.delete();
      m_pc   = {baddr[31:1], 1'b0};
      m_skip = baddr[1];
      fifo_q.delete();
    end else if (m_skip) begin
      if (fv) begin
        pend_q.delete();
        pend_q.push_back(w[31:16]);
        m_skip = 1'b0;
        void'(fifo_q.pop_front());
      end
    end else if (e_hs) begin
      m_pc = m_pc + 32'(e_adv);
      if (e_pop) begin
        pend_q.push_back(w[15:0]);
        pend_q.push_back(w[31:16]);
        void'(fifo_q.pop_front());
      end
      for (int k = 0; k < int'(e_adv) / 2; k++) void'(pend_q.pop_front());
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at posedge+3, commit at posedge.
  task automatic cyc(input logic br, input logic [31:0] baddr, input logic rdy,
                     input logic fv_en, input logic rst);
    logic        fv;
    logic [31:0] w;
    fv = fv_en && (fifo_q.size() > 0);
    w  = fv ? fifo_q[0] : $urandom();
    rst_ni        = rst;
    branch_i      = br;
    branch_addr_i = baddr;
    instr_ready_i = rdy;
    fetch_valid_i = fv;
    fetch_rdata_i = w;
    if (!rst) model_reset();
    model_eval(fv, w, rdy, br, rst);
    #2;
    s_valid = instr_valid_o;
    s_ready = fetch_ready_o;
    s_instr = instr_o;
    s_comp  = instr_compressed_o;
    s_pc    = pc_o;
    chk("valid", 32'(s_valid), 32'(e_valid));
    chk("fetch_ready", 32'(s_ready), 32'(e_ready));
    chk("pc", s_pc, m_pc);
    if (e_valid) begin
      chk("instr", s_instr, e_instr);
      chk("compressed", 32'(s_comp), 32'(is_c(e_instr[15:0])));
    end
    @(posedge clk_i);
    model_commit(fv, w, br, baddr, rst);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
    if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
    return w;
  endfunction

  logic [31:0] hold_instr;

  initial begin
    rst_ni = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    instr_ready_i = 1'b0; fetch_valid_i = 1'b0; fetch_rdata_i = 32'h0;
    model_reset();
    #16;
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("reset_pc", s_pc, 32'h0);
    chk("reset_valid", 32'(s_valid), 32'h0);

    // Two 32-bit instructions after a branch.
    cyc(1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
    fifo_q.push_back(32'h00000013);
    fifo_q.push_back(32'h00100093);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t1_i0", s_instr, 32'h13);
    chk("t1_pc0", s_pc, 32'h100);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t1_i1", s_instr, 32'h00100093);
    chk("t1_pc1", s_pc, 32'h104);

    // Two compressed in one word; the second with the FIFO empty.
    cyc(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    fifo_q.push_back(32'h45014501);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t2_pc0", s_pc, 32'h200);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t2_fv", 32'(fetch_valid_i), 32'h0);
    chk("t2_valid1", 32'(s_valid), 32'h1);
    chk("t2_i1", s_instr, 32'h4501);
    chk("t2_pc1", s_pc, 32'h202);

    // Straddling 32-bit instruction.
    cyc(1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
    fifo_q.push_back(32'h00934501);
    fifo_q.push_back(32'h12340010);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t3_c", s_instr, 32'h4501);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t3_span", s_instr, 32'h00100093);
    chk("t3_pc", s_pc, 32'h2);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t3_resid", s_instr, 32'h1234);
    chk("t3_resid_pc", s_pc, 32'h6);

    // Misaligned branch target: one bubble, lower half dropped.
    cyc(1'b1, 32'h302, 1'b1, 1'b1, 1'b1);
    fifo_q.push_back(32'h4505ABCD);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t4_bubble", 32'(s_valid), 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t4_i", s_instr, 32'h4505);
    chk("t4_pc", s_pc, 32'h302);

    // Stall mid-straddle, then branch while stalled.
    cyc(1'b1, 32'h400, 1'b1, 1'b1, 1'b1);
    fifo_q.push_back(32'h00934501);
    fifo_q.push_back(32'h12340010);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    hold_instr = s_instr;
    chk("t5_first", hold_instr, 32'h00100093);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("t5_stable", s_instr, hold_instr);
      chk("t5_nopop", 32'(s_ready), 32'h0);
    end
    cyc(1'b1, 32'h500, 1'b0, 1'b1, 1'b1);
    chk("t5_br_valid", 32'(s_valid), 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t5_br_pc", s_pc, 32'h500);

    // Reset while MISALIGNED.
    fifo_q.push_back(32'h00934501);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("t6_pc", s_pc, 32'h0);
    chk("t6_valid", 32'(s_valid), 32'h0);
    fifo_q.push_back(32'h00000013);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t6_aligned", s_instr, 32'h13);

    // PC wrap at the top of the address space.
    cyc(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);
    fifo_q.push_back(32'h45010000);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t7_pc", s_pc, 32'hFFFF_FFFE);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("t7_wrap", s_pc, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic        br;
      logic [31:0] ba;
      while (fifo_q.size() < 3) fifo_q.push_back(rand_word());
      br = ($urandom_range(0, 29) == 0);
      ba = $urandom();
      cyc(br, ba, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
          1'($urandom_range(0, 199) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
